dff_delay_line: RTL and testbench
=================================

DFF_DELAY_LINE -- requirements
Module: dff_delay_line

Interface
REQ-001 Parameter WIDTH, default 8: data bits per stage, legal 1..64.
REQ-002 Parameter DEPTH, default 16: physical stage count, legal 2..64.
REQ-003 Parameter SW, default clog2(DEPTH+1): width of sel_delay.
REQ-004 CLK  input  1  clock; all state SHALL update on the rising edge.
REQ-005 RST  input  1  reset; asynchronous, active-low.
REQ-006 en  input  1  advance strobe; 1 shifts the line, 0 holds every stage.
REQ-007 clr  input  1  synchronous flush of the whole line.
REQ-008 sel_delay  input  SW  runtime delay in stages, legal 1..DEPTH.
REQ-009 in_data  input  WIDTH  sample entering stage 0.
REQ-010 in_valid  input  1  qualifies in_data.
REQ-011 out_data  output  WIDTH  data of the selected tap.
REQ-012 out_valid  output  1  valid of the selected tap.
REQ-013 busy  output  1  any valid word held in stages 0..eff_sel-1.
REQ-014 sel_err  output  1  registered flag: sel_delay was illegal on the last edge.

Function
REQ-015 Each stage k (0..DEPTH-1) SHALL hold a WIDTH-bit data register and a 1-bit valid register.
REQ-016 With en=1 and clr=0, stage 0 SHALL load {in_valid, in_valid ? in_data : 0}, and stage k SHALL load stage k-1.
REQ-017 With en=0 and clr=0, every stage SHALL hold its value; in_data and in_valid SHALL be ignored.
REQ-018 clr=1 SHALL zero all data and valid bits on the next edge; clr SHALL take priority over en.
REQ-019 eff_sel SHALL equal sel_delay when 1<=sel_delay<=DEPTH, and DEPTH otherwise (covers 0 and >DEPTH).
REQ-020 out_data and out_valid SHALL be combinational from stage eff_sel-1; no added register.
REQ-021 Latency: a valid word accepted on an en=1 edge SHALL appear on the outputs after exactly eff_sel en=1 edges; en=0 cycles do not count.
REQ-022 out_data SHALL be 0 whenever out_valid=0.
REQ-023 A sel_delay change SHALL retarget the outputs in the same cycle; words already in flight SHALL neither be lost nor duplicated in the stages.
REQ-024 busy SHALL be the OR of valid bits of stages 0..eff_sel-1, computed combinationally.
REQ-025 sel_err SHALL register (sel_delay==0 || sel_delay>DEPTH) on every edge, independent of en and clr.
REQ-026 When en=1 and clr=1 fall on the same edge, the incoming word SHALL be discarded.

Reset
REQ-027 RST low SHALL immediately clear all stage data, all valid bits and sel_err to 0, independent of CLK.
REQ-028 During reset, out_data=0, out_valid=0, busy=0 and sel_err=0.
REQ-029 Reset asserted mid-stream SHALL discard all in-flight words; first output after release follows REQ-021 from the first accepted word.

Structure
REQ-030 Package dff_link_pkg SHALL hold default WIDTH/DEPTH constants and the clog2 function.
REQ-031 One sub-module dff_stage (WIDTH data + valid, inputs en/clr, async active-low reset) SHALL be instantiated DEPTH times via generate.
REQ-032 The tap mux and the busy OR-reduction SHALL live in dff_delay_line.

Verification
REQ-033 WIDTH=8, DEPTH=16, sel=4, en=1, push 0x11,0x22,0x33 valid on successive edges -> out 0x11 valid on 4th edge after its push, then 0x22, 0x33, then out_valid=0, out_data=0.
REQ-034 sel=4, push 0xA5, drop en for 3 cycles after 2 edges -> 0xA5 appears after 4 en=1 edges (7 cycles total), busy=1 until it does.
REQ-035 sel=2 then sel=16 with 0x5A in stage 1 -> outputs switch to stage 15 in the same cycle; 0x5A emerges 14 en edges later.
REQ-036 sel_delay=0 and sel_delay=20 -> behaves as 16-stage delay, sel_err=1 the cycle after each, 0 once sel=3.
REQ-037 Line full of valid words, clr=1 with en=1 and in_valid=1 (0xFF) -> next cycle all valid=0, busy=0, 0xFF never appears.
REQ-038 RST pulsed low between clock edges mid-stream -> outputs 0 immediately; after release first push 0x3C exits after eff_sel edges.

Source files
------------

// File: rtl/dff_link_pkg.sv
// Shared constants and helpers for the DFF delay line.
// Provides default geometry and a constant-evaluable ceiling log2.
package dff_link_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_DEPTH = 16;

   // Number of bits needed to index 'value' distinct codes (0..value-1).
   function automatic int clog2(input int value);
      int result;
      int remaining;
      result    = 0;
      remaining = value - 1;
      while (remaining > 0) begin
         result    = result + 1;
         remaining = remaining >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/dff_stage.sv
// One delay-line stage: WIDTH data bits plus a valid bit.
// Flush has priority over advance; asynchronous active-low reset.
module dff_stage #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] d_data,
   input  logic             d_valid,
   output logic [WIDTH-1:0] q_data,
   output logic             q_valid
);

   logic [WIDTH-1:0] data_reg;
   logic             valid_reg;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         data_reg  <= '0;
         valid_reg <= 1'b0;
      end else if (clr) begin
         data_reg  <= '0;
         valid_reg <= 1'b0;
      end else if (en) begin
         data_reg  <= d_data;
         valid_reg <= d_valid;
      end
   end

   assign q_data  = data_reg;
   assign q_valid = valid_reg;

endmodule

// File: rtl/dff_delay_line.sv
// Runtime-selectable delay line built from DEPTH dff_stage instances.
// Output taps stage eff_sel-1 combinationally; busy covers stages 0..eff_sel-1.
module dff_delay_line
   import dff_link_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int SW    = clog2(DEPTH + 1)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             en,
   input  logic             clr,
   input  logic [SW-1:0]    sel_delay,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   output logic             busy,
   output logic             sel_err
);

   logic [WIDTH-1:0] stage_data [DEPTH];
   logic [DEPTH-1:0] stage_valid;
   logic [WIDTH-1:0] link_data  [DEPTH];
   logic [DEPTH-1:0] link_valid;
   logic [DEPTH-1:0] tap_hit;
   logic [DEPTH-1:0] busy_mask;
   logic [SW-1:0]    eff_sel;
   logic             sel_illegal;
   logic             sel_err_reg;

   // Out-of-range selections fall back to the full physical depth.
   assign sel_illegal = (sel_delay == '0) || (sel_delay > SW'(DEPTH));
   assign eff_sel     = sel_illegal ? SW'(DEPTH) : sel_delay;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
         if (gi == 0) begin : g_head
            // Invalid samples enter as zero so out_data is zero whenever invalid.
            assign link_data[gi]  = in_valid ? in_data : '0;
            assign link_valid[gi] = in_valid;
         end else begin : g_link
            assign link_data[gi]  = stage_data[gi-1];
            assign link_valid[gi] = stage_valid[gi-1];
         end

         dff_stage #(
            .WIDTH(WIDTH)
         ) u_stage (
            .CLK    (CLK),
            .RST    (RST),
            .en     (en),
            .clr    (clr),
            .d_data (link_data[gi]),
            .d_valid(link_valid[gi]),
            .q_data (stage_data[gi]),
            .q_valid(stage_valid[gi])
         );

         assign tap_hit[gi]   = (eff_sel == SW'(gi + 1));
         assign busy_mask[gi] = (SW'(gi + 1) <= eff_sel);
      end
   endgenerate

   always_comb begin
      out_data  = '0;
      out_valid = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         if (tap_hit[k]) begin
            out_valid = stage_valid[k];
            out_data  = stage_valid[k] ? stage_data[k] : '0;
         end
      end
   end

   assign busy = |(stage_valid & busy_mask);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sel_err_reg <= 1'b0;
      end else begin
         sel_err_reg <= sel_illegal;
      end
   end

   assign sel_err = sel_err_reg;

endmodule

// File: tb/tb_dff_delay_line.sv
// Self-checking bench for dff_delay_line (WIDTH=8, DEPTH=16).
// Reference model keeps a timestamped history of accepted words indexed by en-edge count.
module tb_dff_delay_line;

   localparam int WIDTH = 8;
   localparam int DEPTH = 16;
   localparam int SW    = 5;

   logic             CLK = 1'b0;
   logic             RST = 1'b0;
   logic             en = 1'b0;
   logic             clr = 1'b0;
   logic             in_valid = 1'b0;
   logic [SW-1:0]    sel_delay = SW'(4);
   logic [WIDTH-1:0] in_data = '0;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             busy;
   logic             sel_err;

   int vectors = 0;
   int miscompares = 0;

   // Model state: en_count counts accepted advance edges; words stamped at or
   // below floor_count were flushed by clr or reset.
   int             en_count = 0;
   int             floor_count = 0;
   logic           sel_err_m = 1'b0;
   logic [WIDTH:0] hist [0:8191];

   always #5 CLK = ~CLK;

   dff_delay_line #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH),
      .SW   (SW)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .en       (en),
      .clr      (clr),
      .sel_delay(sel_delay),
      .in_data  (in_data),
      .in_valid (in_valid),
      .out_data (out_data),
      .out_valid(out_valid),
      .busy     (busy),
      .sel_err  (sel_err)
   );

   function automatic int eff(input int s);
      return (s >= 1 && s <= DEPTH) ? s : DEPTH;
   endfunction

   // A word stamped ts is visible at delay s once en_count - ts + 1 == s.
   function automatic logic [WIDTH:0] model_tap(input int s);
      int ts;
      ts = en_count - eff(s) + 1;
      if (ts > floor_count && ts >= 1) return hist[ts];
      return '0;
   endfunction

   function automatic logic model_busy(input int s);
      for (int ts = en_count - eff(s) + 1; ts <= en_count; ts++) begin
         if (ts > floor_count && ts >= 1 && hist[ts][WIDTH]) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic drive(input logic e, input logic c, input logic v,
                        input logic [WIDTH-1:0] d, input int s);
      @(negedge CLK);
      en        = e;
      clr       = c;
      in_valid  = v;
      in_data   = d;
      sel_delay = SW'(s);
      #1;
   endtask

   // Advance the model across one rising edge using the inputs held there.
   task automatic tick();
      @(posedge CLK);
      sel_err_m = (sel_delay == 0) || (sel_delay > DEPTH);
      if (clr) begin
         floor_count = en_count;
      end else if (en) begin
         en_count = en_count + 1;
         hist[en_count] = {in_valid, in_valid ? in_data : {WIDTH{1'b0}}};
      end
   endtask

   task automatic test_reset();
      en = 1'b1; in_valid = 1'b1; in_data = 8'hAA; sel_delay = '0;
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK);
         #2;
         vectors++;
         if (out_data !== 8'h00 || out_valid !== 1'b0 || busy !== 1'b0 || sel_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: data=%h valid=%b busy=%b sel_err=%b required all 0",
                     out_data, out_valid, busy, sel_err);
         end
      end
      @(negedge CLK);
      en = 1'b0; in_valid = 1'b0; in_data = '0; sel_delay = SW'(4);
      RST = 1'b1;
   endtask

   task automatic test_push_sequence();
      logic [WIDTH-1:0] exp_d [8];
      logic [WIDTH-1:0] push_d [3];
      logic [WIDTH:0]   m;
      exp_d = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
      push_d = '{8'h11, 8'h22, 8'h33};
      drive(1'b0, 1'b1, 1'b0, '0, 4); tick();
      for (int i = 0; i < 8; i++) begin
         if (i < 3) drive(1'b1, 1'b0, 1'b1, push_d[i], 4);
         else       drive(1'b1, 1'b0, 1'b0, 8'h00, 4);
         m = model_tap(4);
         vectors++;
         if (out_data !== exp_d[i] || out_valid !== (exp_d[i] != 0) ||
             out_data !== m[WIDTH-1:0] || busy !== model_busy(4) || sel_err !== sel_err_m) begin
            miscompares++;
            $display("FAIL push_seq step %0d: data=%h valid=%b busy=%b required data=%h busy=%b",
                     i, out_data, out_valid, busy, exp_d[i], model_busy(4));
         end
         tick();
      end
   endtask

   task automatic test_hold();
      logic [7:0]     en_pat;
      logic [WIDTH:0] m;
      en_pat = 8'b1110_0011;  // bit i = en at step i
      drive(1'b0, 1'b1, 1'b0, '0, 4); tick();
      for (int i = 0; i < 8; i++) begin
         drive(en_pat[i], 1'b0, (i == 0), (i == 0) ? 8'hA5 : 8'h5C, 4);
         m = model_tap(4);
         vectors++;
         if (out_valid !== m[WIDTH] || out_data !== m[WIDTH-1:0] || busy !== model_busy(4) ||
             (i == 7 && (out_data !== 8'hA5 || out_valid !== 1'b1)) ||
             (i >= 1 && busy !== 1'b1) || (i < 7 && out_valid !== 1'b0)) begin
            miscompares++;
            $display("FAIL hold step %0d: data=%h valid=%b busy=%b required data=%h valid=%b busy=%b",
                     i, out_data, out_valid, busy, m[WIDTH-1:0], m[WIDTH], model_busy(4));
         end
         tick();
      end
   endtask

   task automatic test_retarget();
      logic [WIDTH:0] m;
      drive(1'b0, 1'b1, 1'b0, '0, 2); tick();
      drive(1'b1, 1'b0, 1'b1, 8'h5A, 2); tick();
      drive(1'b1, 1'b0, 1'b0, 8'h00, 2); tick();
      drive(1'b0, 1'b0, 1'b0, 8'h00, 2);
      vectors++;
      if (out_data !== 8'h5A || out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL retarget_sel2: data=%h valid=%b required 5a/1", out_data, out_valid);
      end
      tick();
      for (int i = 0; i <= 14; i++) begin
         drive((i != 0), 1'b0, 1'b0, 8'h00, 16);
         m = model_tap(16);
         vectors++;
         if (out_valid !== m[WIDTH] || out_data !== m[WIDTH-1:0] || busy !== 1'b1 ||
             (i == 14 && out_data !== 8'h5A) || (i < 14 && out_valid !== 1'b0)) begin
            miscompares++;
            $display("FAIL retarget_sel16 step %0d: data=%h valid=%b busy=%b required data=%h valid=%b",
                     i, out_data, out_valid, busy, m[WIDTH-1:0], m[WIDTH]);
         end
         if (i != 0) tick();
         else begin
            drive(1'b1, 1'b0, 1'b0, 8'h00, 16); tick();
         end
      end
   endtask

   task automatic test_illegal_sel();
      int             sels [3];
      logic [WIDTH:0] m;
      sels = '{0, 20, 3};
      for (int j = 0; j < 3; j++) begin
         for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom), sels[j]);
            m = model_tap(sels[j]);
            vectors++;
            if (out_valid !== m[WIDTH] || out_data !== m[WIDTH-1:0] ||
                busy !== model_busy(sels[j]) || sel_err !== sel_err_m ||
                (i > 0 && sel_err !== (sels[j] != 3))) begin
               miscompares++;
               $display("FAIL illegal_sel sel=%0d step %0d: data=%h valid=%b busy=%b sel_err=%b required data=%h valid=%b busy=%b sel_err=%b",
                        sels[j], i, out_data, out_valid, busy, sel_err,
                        m[WIDTH-1:0], m[WIDTH], model_busy(sels[j]), sel_err_m);
            end
            tick();
         end
      end
   endtask

   task automatic test_clr_full();
      logic [WIDTH:0] m;
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 1'b0, 1'b1, 8'($urandom_range(1, 254)), 16); tick();
      end
      drive(1'b1, 1'b1, 1'b1, 8'hFF, 16);
      vectors++;
      if (out_valid !== 1'b1 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL clr_full_before: valid=%b busy=%b required 1/1", out_valid, busy);
      end
      tick();
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 1'b0, 1'b0, 8'h00, 16);
         m = model_tap(16);
         vectors++;
         if (out_valid !== m[WIDTH] || out_data !== m[WIDTH-1:0] || busy !== model_busy(16) ||
             out_data === 8'hFF || (i == 0 && (busy !== 1'b0 || out_valid !== 1'b0))) begin
            miscompares++;
            $display("FAIL clr_full step %0d: data=%h valid=%b busy=%b required data=%h valid=%b busy=%b",
                     i, out_data, out_valid, busy, m[WIDTH-1:0], m[WIDTH], model_busy(16));
         end
         tick();
      end
   endtask

   task automatic test_reset_midstream();
      logic [WIDTH:0] m;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 1'b0, 1'b1, 8'($urandom_range(1, 255)), 20); tick();
      end
      @(negedge CLK);
      en = 1'b0; in_valid = 1'b0;
      #2 RST = 1'b0;
      #1;
      floor_count = en_count;
      sel_err_m = 1'b0;
      vectors++;
      if (out_data !== 8'h00 || out_valid !== 1'b0 || busy !== 1'b0 || sel_err !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_midstream: data=%h valid=%b busy=%b sel_err=%b required all 0",
                  out_data, out_valid, busy, sel_err);
      end
      #1 RST = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b0, (i == 0), (i == 0) ? 8'h3C : 8'h00, 5);
         m = model_tap(5);
         vectors++;
         if (out_valid !== m[WIDTH] || out_data !== m[WIDTH-1:0] || busy !== model_busy(5) ||
             (i == 5 && out_data !== 8'h3C) || (i < 5 && out_valid !== 1'b0)) begin
            miscompares++;
            $display("FAIL reset_release step %0d: data=%h valid=%b busy=%b required data=%h valid=%b",
                     i, out_data, out_valid, busy, m[WIDTH-1:0], m[WIDTH]);
         end
         tick();
      end
   endtask

   task automatic test_random();
      logic [WIDTH:0] m;
      int             s;
      for (int i = 0; i < 300; i++) begin
         s = $urandom_range(0, 20);
         drive(($urandom % 4) != 0, ($urandom % 25) == 0, 1'($urandom), 8'($urandom), s);
         m = model_tap(s);
         vectors++;
         if (out_valid !== m[WIDTH] || out_data !== m[WIDTH-1:0] ||
             busy !== model_busy(s) || sel_err !== sel_err_m) begin
            miscompares++;
            $display("FAIL random cycle %0d sel=%0d: data=%h valid=%b busy=%b sel_err=%b required data=%h valid=%b busy=%b sel_err=%b",
                     i, s, out_data, out_valid, busy, sel_err,
                     m[WIDTH-1:0], m[WIDTH], model_busy(s), sel_err_m);
         end
         tick();
      end
   endtask

   initial begin
      for (int i = 0; i < 8192; i++) hist[i] = '0;
      test_reset();
      test_push_sequence();
      test_hold();
      test_retarget();
      test_illegal_sel();
      test_clr_full();
      test_reset_midstream();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
